// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch next-PC generator.
// Optional feature macro used by bp_fetch_pcgen: BP_PERF_CNT_EN.
package bp_pkg;

    localparam int BP_INSTR_SIZE_BYTE = 4;
    localparam int BP_XLEN            = BP_INSTR_SIZE_BYTE * 8;

    // One in-flight prediction, checked in order against execute.
    typedef struct packed {
        logic [BP_XLEN-1:0] pc;
        logic               taken;
        logic [BP_XLEN-1:0] offset;
    } pred_entry_t;

    // Fall-through PC; wraps modulo 2^XLEN.
    function automatic logic [BP_XLEN-1:0] next_seq_pc(input logic [BP_XLEN-1:0] pc);
        return pc + BP_XLEN'(BP_INSTR_SIZE_BYTE);
    endfunction

endpackage

// File: rtl/bp_pred_queue.sv
// In-order queue of in-flight predictions: push, pop, whole-queue clear,
// occupancy count and head read. Clear wins over push/pop in the same cycle.
module bp_pred_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  pred_entry_t wdata_i,
    input  logic        pop_i,
    input  logic        clear_i,
    output logic [PW:0] count_o,
    output pred_entry_t head_o
);

    pred_entry_t       mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]       count_q, count_d;

    // Next pointers/count; power-of-two depth lets pointers wrap naturally.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/bp_fetch_pcgen.sv
// Fetch next-PC generator: issues the fetch PC to the predictor, follows
// its same-cycle prediction, queues each prediction and checks it against
// execute, flushing/redirecting on a mispredict.
// Optional: BP_PERF_CNT_EN adds saturating branch/mispredict counters.
// Entry fields are sized by bp_pkg::BP_XLEN; keep INSTR_SIZE_BYTE in step.
module bp_fetch_pcgen
    import bp_pkg::*;
#(
    parameter int                                INSTR_SIZE_BYTE = BP_INSTR_SIZE_BYTE,
    parameter logic [INSTR_SIZE_BYTE*8-1:0]      RESET_PC        = '0,
    parameter int                                PRED_Q_DEPTH    = 8,
    localparam int                               XLEN            = INSTR_SIZE_BYTE * 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_stall,
    output logic [XLEN-1:0] out_fetch_pc,
    output logic            out_fetch_nop,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_offset,
    input  logic            in_exe_nop,
    input  logic [XLEN-1:0] in_exe_pc,
    input  logic            in_exe_branch_taken,
    input  logic [XLEN-1:0] in_exe_branch_offset,
    output logic            out_flush,
    output logic [XLEN-1:0] out_redirect_pc,
`ifdef BP_PERF_CNT_EN
    output logic [31:0]     out_br_cnt,
    output logic [31:0]     out_mispred_cnt,
`endif
    output logic            out_seq_err
);

    localparam int PW = $clog2(PRED_Q_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            seq_err_q, seq_err_d;
    logic [PW:0]     q_cnt;
    pred_entry_t     head, wentry;
    logic            full, empty, fire, pop_vld, mispred;
    logic [XLEN-1:0] exe_target;

    assign full  = (q_cnt == (PW+1)'(PRED_Q_DEPTH));
    assign empty = (q_cnt == '0);

    // Issue uses the pre-pop count, so a full queue stalls one cycle even
    // while it drains. Reset forces a bubble.
    assign fire    = rst_n && !in_stall && !full && !out_flush;
    assign pop_vld = !in_exe_nop && !empty;
    assign mispred = pop_vld && ((head.taken != in_exe_branch_taken) ||
                                 (in_exe_branch_taken && head.offset != in_exe_branch_offset));

    assign exe_target      = in_exe_branch_taken ? in_exe_pc + in_exe_branch_offset
                                                 : next_seq_pc(in_exe_pc);
    assign out_flush       = mispred;
    assign out_redirect_pc = mispred ? exe_target : '0;
    assign out_fetch_pc    = pc_q;
    assign out_fetch_nop   = !fire;
    assign out_seq_err     = seq_err_q;

    assign wentry = '{pc: pc_q, taken: in_pred_taken, offset: in_pred_offset};

    bp_pred_queue #(.DEPTH(PRED_Q_DEPTH)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fire),
        .wdata_i (wentry),
        .pop_i   (pop_vld),
        .clear_i (mispred),
        .count_o (q_cnt),
        .head_o  (head)
    );

    // Next fetch PC and sticky ordering error.
    always_comb begin
        pc_d      = pc_q;
        seq_err_d = seq_err_q;
        if (out_flush)
            pc_d = exe_target;
        else if (fire)
            pc_d = in_pred_taken ? pc_q + in_pred_offset : next_seq_pc(pc_q);
        if (!in_exe_nop && (empty || head.pc != in_exe_pc))
            seq_err_d = 1'b1;
    end

    // Fetch PC and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            seq_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            seq_err_q <= seq_err_d;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] br_cnt_q, mis_cnt_q;

    // Saturating counts of resolved branches and flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (pop_vld && (in_exe_branch_taken || head.taken) && br_cnt_q != '1)
                br_cnt_q <= br_cnt_q + 32'd1;
            if (out_flush && mis_cnt_q != '1)
                mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign out_br_cnt      = br_cnt_q;
    assign out_mispred_cnt = mis_cnt_q;
`endif

endmodule

// File: tb/tb_bp_fetch_pcgen.sv
// Bench for bp_fetch_pcgen: predictions are pushed to a scoreboard queue
// as they issue and popped/compared as execute resolves them.
module tb_bp_fetch_pcgen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_stall, in_pred_taken, in_exe_nop, in_exe_branch_taken;
    logic [31:0] in_pred_offset, in_exe_pc, in_exe_branch_offset;
    logic [31:0] out_fetch_pc, out_redirect_pc;
    logic        out_fetch_nop, out_flush, out_seq_err;
`ifdef BP_PERF_CNT_EN
    logic [31:0] out_br_cnt, out_mispred_cnt;
    int          m_br, m_mis;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] off;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_err;
    int          total = 0;
    int          bad   = 0;
    logic        last_nop, last_flush;
    logic [31:0] last_red;

    always #5 clk = ~clk;

    bp_fetch_pcgen dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_stall             (in_stall),
        .out_fetch_pc         (out_fetch_pc),
        .out_fetch_nop        (out_fetch_nop),
        .in_pred_taken        (in_pred_taken),
        .in_pred_offset       (in_pred_offset),
        .in_exe_nop           (in_exe_nop),
        .in_exe_pc            (in_exe_pc),
        .in_exe_branch_taken  (in_exe_branch_taken),
        .in_exe_branch_offset (in_exe_branch_offset),
        .out_flush            (out_flush),
        .out_redirect_pc      (out_redirect_pc),
`ifdef BP_PERF_CNT_EN
        .out_br_cnt           (out_br_cnt),
        .out_mispred_cnt      (out_mispred_cnt),
`endif
        .out_seq_err          (out_seq_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc  = 32'h0;
        m_err = 1'b0;
`ifdef BP_PERF_CNT_EN
        m_br  = 0;
        m_mis = 0;
`endif
    endtask

    // One cycle: drive, compare at negedge against the scoreboard, advance.
    task automatic cyc(input logic s, input logic pt, input logic [31:0] po,
                       input logic ev, input logic [31:0] ep,
                       input logic et, input logic [31:0] eo);
        logic        pop, fl, fire;
        logic [31:0] red;
        in_stall = s; in_pred_taken = pt; in_pred_offset = po;
        in_exe_nop = !ev; in_exe_pc = ep; in_exe_branch_taken = et; in_exe_branch_offset = eo;
        @(negedge clk);
        pop  = ev && mq.size() > 0;
        fl   = pop && ((mq[0].tk != et) || (et && mq[0].off != eo));
        red  = fl ? (et ? ep + eo : ep + 32'd4) : 32'd0;
        fire = !s && mq.size() < 8 && !fl;
        chk("fetch_pc", out_fetch_pc, m_pc);
        chk("fetch_nop", 32'(out_fetch_nop), 32'(!fire));
        chk("flush", 32'(out_flush), 32'(fl));
        chk("redirect", out_redirect_pc, red);
        chk("seq_err", 32'(out_seq_err), 32'(m_err));
        last_nop = out_fetch_nop; last_flush = out_flush; last_red = out_redirect_pc;
        if (ev && (mq.size() == 0 || mq[0].pc != ep)) m_err = 1'b1;
`ifdef BP_PERF_CNT_EN
        if (pop && (et || mq[0].tk)) m_br++;
        if (fl) m_mis++;
`endif
        if (fl) begin
            mq.delete();
            m_pc = red;
        end else begin
            if (pop) void'(mq.pop_front());
            if (fire) begin
                mq.push_back('{m_pc, pt, po});
                m_pc = pt ? m_pc + po : m_pc + 32'd4;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_stall = 1'b0; in_pred_taken = 1'b0; in_pred_offset = '0;
        in_exe_nop = 1'b1; in_exe_pc = '0; in_exe_branch_taken = 1'b0; in_exe_branch_offset = '0;
        model_reset();
        #12;
        chk("rst_pc", out_fetch_pc, 32'h0);
        chk("rst_nop", 32'(out_fetch_nop), 32'd1);
        chk("rst_flush", 32'(out_flush), 32'd0);
        chk("rst_red", out_redirect_pc, 32'd0);
        chk("rst_err", 32'(out_seq_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Sequential fetch until the queue fills.
        idle(10);
        chk("full_pc", out_fetch_pc, 32'h20);
        chk("full_nop", 32'(out_fetch_nop), 32'd1);

        // Full with a correct pop: no issue that cycle, issue the next.
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
        chk("full_pop_nop", 32'(last_nop), 32'd1);
        idle(1);
        chk("after_pop_issue", 32'(last_nop), 32'd0);

        // Mispredict on head {4,nt} -> redirect 0x10.
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, 32'hC);
        chk("fl1_flush", 32'(last_flush), 32'd1);
        chk("fl1_pc", out_fetch_pc, 32'h10);

        // Predicted taken at 0x10 (+0x40), resolved not taken.
        cyc(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("pred_tk_pc", out_fetch_pc, 32'h50);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0);
        chk("nt_red", last_red, 32'h14);
        chk("nt_pc", out_fetch_pc, 32'h14);

        // Negative offset wraps back to 0x10.
        idle(1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h14, 1'b1, 32'hFFFF_FFFC);
        chk("neg_red", last_red, 32'h10);

        // Predicted not-taken at 0x10, actually taken +0x100.
        idle(1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h100);
        chk("tk_flush", 32'(last_flush), 32'd1);
        chk("tk_red", last_red, 32'h110);
        chk("tk_pc", out_fetch_pc, 32'h110);

        // PC wraps past the top of the address space.
        idle(1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h110, 1'b1, 32'hFFFF_FEEC);
        chk("wrap_red", last_red, 32'hFFFF_FFFC);
        idle(1);
        chk("wrap_pc", out_fetch_pc, 32'h0);

        // Stall holds PC and suppresses issue.
        cyc(1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("stall_nop", 32'(last_nop), 32'd1);
        chk("stall_pc", out_fetch_pc, 32'h0);

        // Mixed random traffic; resolutions always follow queue order.
        for (int i = 0; i < 300; i++) begin
            logic        s, pt, ev, et;
            logic [31:0] po, ep, eo;
            s  = ($urandom_range(0, 3) == 0);
            pt = ($urandom_range(0, 3) == 0);
            po = {24'h0, 6'($urandom_range(1, 63)), 2'b00};
            ev = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            ep = 32'h0; et = 1'b0; eo = 32'h0;
            if (ev) begin
                ep = mq[0].pc; et = mq[0].tk; eo = mq[0].off;
                if ($urandom_range(0, 9) == 0) begin
                    et = !et;
                    eo = {24'h0, 6'($urandom_range(1, 63)), 2'b00};
                end
            end
            cyc(s, pt, po, ev, ep, et, eo);
        end

        // Empty the queue, then resolve with nothing in flight.
        if (mq.size() > 0)
            cyc(1'b1, 1'b0, 32'h0, 1'b1, mq[0].pc, !mq[0].tk, 32'h40);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h1234, 1'b1, 32'h8);
        chk("uf_flush", 32'(last_flush), 32'd0);
        chk("uf_err", 32'(out_seq_err), 32'd1);
        idle(3);
        chk("uf_sticky", 32'(out_seq_err), 32'd1);

`ifdef BP_PERF_CNT_EN
        chk("br_cnt", out_br_cnt, 32'(m_br));
        chk("mis_cnt", out_mispred_cnt, 32'(m_mis));
`endif

        // Asynchronous reset mid-stream.
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_err", 32'(out_seq_err), 32'd0);
        chk("mrst_pc", out_fetch_pc, 32'h0);
        chk("mrst_nop", 32'(out_fetch_nop), 32'd1);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(3);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
        chk("post_rst_pc", out_fetch_pc, 32'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
